// File: rtl/axilite4_pkg.sv
// Shared widths, response codes and FSM state types for the AXI-Lite memory slave.
package axilite4_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 128;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;
    localparam int AXI_RESP_W = 32;

    // Latency counters are wide enough for any practical memory delay.
    localparam int LAT_CNT_W = 16;

    localparam logic [AXI_RESP_W-1:0] RESP_OK       = 32'h0;
    localparam logic [AXI_RESP_W-1:0] RESP_ADDR_ERR = 32'h1;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT,
        W_RESP
    } wr_state_e;

endpackage

// File: rtl/line_ram_be.sv
// Line-wide RAM with a registered read port and a byte-enabled write port.
module line_ram_be
    import axilite4_pkg::*;
#(
    parameter int LINES  = 1024,
    parameter int DATA_W = AXI_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_en_i,
    input  logic                     rd_zero_i,
    input  logic [$clog2(LINES)-1:0] rd_idx_i,
    output logic [DATA_W-1:0]        rd_data_o,
    input  logic                     wr_en_i,
    input  logic [$clog2(LINES)-1:0] wr_idx_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic [DATA_W/8-1:0]      wr_be_i
);

    logic [DATA_W-1:0] mem_q [LINES];
    logic [DATA_W-1:0] rd_data_q;

    // Byte-enabled write of one line.
    // NOTE: the array has no reset branch on purpose -- contents survive rst and a reset loop over every line would not map onto RAM macros.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (wr_be_i[b]) begin
                    mem_q[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
                end
            end
        end
    end

    // Registered read; the register holds its value until the next read so it doubles as the response payload.
    // NOTE: non-blocking assignments on both the array and this register are what make a same-edge read return the old line.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= rd_zero_i ? '0 : mem_q[rd_idx_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axilite4_mem_slave.sv
// AXI-Lite-style line memory slave: independent read and write channels with programmable latency.
module axilite4_mem_slave
    import axilite4_pkg::*;
#(
    parameter int ADDR_WIDTH    = AXI_ADDR_W,
    parameter int DATA_WIDTH    = AXI_DATA_W,
    parameter int MEM_LINES     = 1024,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   readAddr_addr,
    input  logic                    readAddr_valid,
    output logic                    readAddr_ready,
    output logic [DATA_WIDTH-1:0]   readData_data,
    output logic                    readData_valid,
    input  logic                    readData_ready,
    input  logic [ADDR_WIDTH-1:0]   writeAddr_addr,
    input  logic                    writeAddr_valid,
    output logic                    writeAddr_ready,
    input  logic [DATA_WIDTH-1:0]   writeData_data,
    input  logic [DATA_WIDTH/8-1:0] writeData_strb,
    input  logic                    writeData_valid,
    output logic                    writeData_ready,
    output logic [AXI_RESP_W-1:0]   writeResp_msg,
    output logic                    writeResp_valid,
    input  logic                    writeResp_ready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_W      = $clog2(MEM_LINES);

    // Read channel state
    rd_state_e            r_state_q;
    logic [LAT_CNT_W-1:0] r_cnt_q;
    logic [IDX_W-1:0]     r_idx_q;
    logic                 r_oor_q;
    logic                 r_valid_q;
    logic                 r_hs;
    logic                 r_sample;

    // Write channel state
    wr_state_e            w_state_q;
    logic [LAT_CNT_W-1:0] w_cnt_q;
    logic                 aw_held_q;
    logic                 w_held_q;
    logic [IDX_W-1:0]     w_idx_q;
    logic                 w_oor_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_WIDTH-1:0] w_strb_q;
    logic                 b_valid_q;
    logic [AXI_RESP_W-1:0] b_msg_q;
    logic                 aw_hs;
    logic                 w_hs;
    logic                 w_commit;

    logic [DATA_WIDTH-1:0] ram_rdata;

    // Byte offset within a line never selects anything.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{readAddr_addr[3:0], writeAddr_addr[3:0]};

    assign r_hs     = readAddr_valid & readAddr_ready;
    assign r_sample = (r_state_q == R_WAIT) && (r_cnt_q == LAT_CNT_W'(1));

    assign aw_hs    = writeAddr_valid & writeAddr_ready;
    assign w_hs     = writeData_valid & writeData_ready;
    assign w_commit = (w_state_q == W_WAIT) && (w_cnt_q == LAT_CNT_W'(1));

    // Channel outputs are forced quiet for as long as rst is high.
    assign readAddr_ready  = (r_state_q == R_IDLE) & ~rst;
    assign readData_valid  = r_valid_q & ~rst;
    assign readData_data   = rst ? '0 : ram_rdata;
    assign writeAddr_ready = (w_state_q == W_IDLE) & ~aw_held_q & ~rst;
    assign writeData_ready = (w_state_q == W_IDLE) & ~w_held_q & ~rst;
    assign writeResp_valid = b_valid_q & ~rst;
    assign writeResp_msg   = rst ? '0 : b_msg_q;

    // Read FSM: accept address, count down the latency, then hold the line until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            r_cnt_q   <= '0;
            r_idx_q   <= '0;
            r_oor_q   <= 1'b0;
            r_valid_q <= 1'b0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (r_hs) begin
                        r_idx_q   <= readAddr_addr[IDX_W+3:4];
                        r_oor_q   <= |readAddr_addr[ADDR_WIDTH-1:IDX_W+4];
                        r_cnt_q   <= LAT_CNT_W'(READ_LATENCY);
                        r_state_q <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    r_cnt_q <= r_cnt_q - 1'b1;
                    if (r_sample) begin
                        r_valid_q <= 1'b1;
                        r_state_q <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (readData_ready) begin
                        r_valid_q <= 1'b0;
                        r_state_q <= R_IDLE;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    // Write FSM: collect address and data in any order, count down, commit, then hold the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            w_cnt_q   <= '0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            w_idx_q   <= '0;
            w_oor_q   <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            b_valid_q <= 1'b0;
            b_msg_q   <= RESP_OK;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (aw_hs) begin
                        w_idx_q   <= writeAddr_addr[IDX_W+3:4];
                        w_oor_q   <= |writeAddr_addr[ADDR_WIDTH-1:IDX_W+4];
                        aw_held_q <= 1'b1;
                    end
                    if (w_hs) begin
                        w_data_q <= writeData_data;
                        w_strb_q <= writeData_strb;
                        w_held_q <= 1'b1;
                    end
                    if ((aw_held_q | aw_hs) && (w_held_q | w_hs)) begin
                        w_cnt_q   <= LAT_CNT_W'(WRITE_LATENCY);
                        w_state_q <= W_WAIT;
                    end
                end
                W_WAIT: begin
                    w_cnt_q <= w_cnt_q - 1'b1;
                    if (w_commit) begin
                        b_msg_q   <= w_oor_q ? RESP_ADDR_ERR : RESP_OK;
                        b_valid_q <= 1'b1;
                        w_state_q <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (writeResp_ready) begin
                        b_valid_q <= 1'b0;
                        aw_held_q <= 1'b0;
                        w_held_q  <= 1'b0;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // A commit coinciding with rst is dropped along with the rest of the transaction.
    line_ram_be #(
        .LINES  (MEM_LINES),
        .DATA_W (DATA_WIDTH)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .rd_en_i   (r_sample),
        .rd_zero_i (r_oor_q),
        .rd_idx_i  (r_idx_q),
        .rd_data_o (ram_rdata),
        .wr_en_i   (w_commit & ~w_oor_q & ~rst),
        .wr_idx_i  (w_idx_q),
        .wr_data_i (w_data_q),
        .wr_be_i   (w_strb_q)
    );

endmodule
